// File: rtl/alu_seq_responder.sv
// ============================================================================
// Module   : alu_seq_responder
// Brief    : Handshaked multi-cycle ALU; shifts/rotates iterate one bit/cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq_responder #(
    parameter int OPERAND_WIDTH = 16,
    parameter int SHAMT_WIDTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [OPERAND_WIDTH-1:0] InA,
    input  logic [OPERAND_WIDTH-1:0] InB,
    input  logic                     Cin,
    input  logic [2:0]               Oper,
    input  logic                     invA,
    input  logic                     invB,
    input  logic                     sign,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [OPERAND_WIDTH-1:0] Out,
    output logic                     Ofl,
    output logic                     Zero,
    output logic                     Cout,
    output logic                     Neg
);

    localparam int MSB = OPERAND_WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [OPERAND_WIDTH-1:0] a_q, a_d;
    logic [OPERAND_WIDTH-1:0] b_q, b_d;
    logic                     cin_q, cin_d;
    logic                     sign_q, sign_d;
    logic [2:0]               oper_q, oper_d;
    logic [SHAMT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [OPERAND_WIDTH-1:0] out_q, out_d;
    logic                     ofl_q, ofl_d;
    logic                     zero_q, zero_d;
    logic                     cout_q, cout_d;
    logic                     neg_q, neg_d;
    logic                     resp_valid_q, resp_valid_d;

    logic [OPERAND_WIDTH-1:0] b_in;
    logic [OPERAND_WIDTH:0]   sum;
    logic [OPERAND_WIDTH-1:0] res;

    assign b_in = invB ? ~InB : InB;
    assign sum  = {1'b0, a_q} + {1'b0, b_q} + {{OPERAND_WIDTH{1'b0}}, cin_q};

    // Shift opcodes leave their finished value in the working register.
    always_comb begin
        res = a_q;
        case (oper_q)
            3'b100:  res = sum[MSB:0];
            3'b101:  res = a_q & b_q;
            3'b110:  res = a_q | b_q;
            3'b111:  res = a_q ^ b_q;
            default: res = a_q;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        cin_d        = cin_q;
        sign_d       = sign_q;
        oper_d       = oper_q;
        cnt_d        = cnt_q;
        out_d        = out_q;
        ofl_d        = ofl_q;
        zero_d       = zero_q;
        cout_d       = cout_q;
        neg_d        = neg_q;
        resp_valid_d = resp_valid_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    a_d     = invA ? ~InA : InA;
                    b_d     = b_in;
                    cin_d   = Cin;
                    sign_d  = sign;
                    oper_d  = Oper;
                    cnt_d   = b_in[SHAMT_WIDTH-1:0];
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!oper_q[2] && (cnt_q != '0)) begin
                    case (oper_q[1:0])
                        2'b00:   a_d = {a_q[MSB-1:0], a_q[MSB]};
                        2'b01:   a_d = {a_q[MSB-1:0], 1'b0};
                        2'b10:   a_d = {a_q[0], a_q[MSB:1]};
                        default: a_d = {1'b0, a_q[MSB:1]};
                    endcase
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    out_d        = res;
                    zero_d       = (res == '0);
                    neg_d        = res[MSB];
                    cout_d       = (oper_q == 3'b100) ? sum[OPERAND_WIDTH] : 1'b0;
                    ofl_d        = 1'b0;
                    if (oper_q == 3'b100) begin
                        ofl_d = sign_q ? (sum[MSB] ^ a_q[MSB] ^ b_q[MSB] ^ sum[OPERAND_WIDTH])
                                       : sum[OPERAND_WIDTH];
                    end
                    resp_valid_d = 1'b1;
                    state_d      = S_DONE;
                end
            end
            S_DONE: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            cin_q        <= 1'b0;
            sign_q       <= 1'b0;
            oper_q       <= '0;
            cnt_q        <= '0;
            out_q        <= '0;
            ofl_q        <= 1'b0;
            zero_q       <= 1'b0;
            cout_q       <= 1'b0;
            neg_q        <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            cin_q        <= cin_d;
            sign_q       <= sign_d;
            oper_q       <= oper_d;
            cnt_q        <= cnt_d;
            out_q        <= out_d;
            ofl_q        <= ofl_d;
            zero_q       <= zero_d;
            cout_q       <= cout_d;
            neg_q        <= neg_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = resp_valid_q;
    assign Out        = out_q;
    assign Ofl        = ofl_q;
    assign Zero       = zero_q;
    assign Cout       = cout_q;
    assign Neg        = neg_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_responder.sv
// ============================================================================
// Module   : tb_alu_seq_responder
// Brief    : Directed scoreboard bench for alu_seq_responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_seq_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] InA = '0;
    logic [15:0] InB = '0;
    logic        Cin = 1'b0;
    logic [2:0]  Oper = '0;
    logic        invA = 1'b0;
    logic        invB = 1'b0;
    logic        sign = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [15:0] Out;
    logic        Ofl, Zero, Cout, Neg;

    alu_seq_responder #(.OPERAND_WIDTH(16), .SHAMT_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .InA(InA), .InB(InB), .Cin(Cin), .Oper(Oper), .invA(invA), .invB(invB),
        .sign(sign), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .Out(Out), .Ofl(Ofl), .Zero(Zero), .Cout(Cout), .Neg(Neg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] out;
        logic        ofl, zero, cout, neg;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cycle    = 0;
    logic prev_v   = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    // Monitor: samples on the falling edge, away from all DUT and driver activity.
    always @(negedge clk) begin
        if (rst && resp_valid) begin
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_resp got Out=%h with no request outstanding", Out);
            end else begin
                mon_e = sb[0];
                if (!prev_v) begin
                    checks++;
                    if (cycle != mon_e.acc + mon_e.lat) begin
                        failures++;
                        $display("FAIL latency got %0d edges expected %0d",
                                 cycle - mon_e.acc, mon_e.lat);
                    end
                end
                checks++;
                if ({Out, Ofl, Zero, Cout, Neg} !==
                    {mon_e.out, mon_e.ofl, mon_e.zero, mon_e.cout, mon_e.neg}) begin
                    failures++;
                    $display("FAIL resp got Out=%h O=%b Z=%b C=%b N=%b expected Out=%h O=%b Z=%b C=%b N=%b",
                             Out, Ofl, Zero, Cout, Neg,
                             mon_e.out, mon_e.ofl, mon_e.zero, mon_e.cout, mon_e.neg);
                end
                if (resp_ready) void'(sb.pop_front());
            end
        end
        prev_v = rst && resp_valid;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s got %h expected %h", name, act, expv);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(sb.size() == 0 && req_ready) && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", {31'b0, (sb.size() == 0 && req_ready)}, 32'd1);
    endtask

    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic ia, input logic ib, input logic sg,
                         input logic [15:0] e_out, input logic e_ofl, input logic e_zero,
                         input logic e_cout, input logic e_neg, input int lat,
                         input logic push);
        exp_t e;
        wait_idle();
        Oper = op; InA = a; InB = b; Cin = c; invA = ia; invB = ib; sign = sg;
        req_valid = 1'b1;
        @(posedge clk); #1;
        e.out = e_out; e.ofl = e_ofl; e.zero = e_zero; e.cout = e_cout; e.neg = e_neg;
        e.lat = lat; e.acc = cycle;
        if (push) sb.push_back(e);
        req_valid = 1'b0;
        InA = 16'hDEAD; InB = 16'hBEEF; Cin = 1'b1; invA = 1'b1; invB = 1'b1; Oper = 3'b011;
    endtask

    initial begin
        #1;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_outputs", {10'b0, resp_valid, Out, Ofl, Zero, Cout, Neg}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        //     op      InA       InB       Cin ia ib sg  Out      O Z C N  lat
        issue(3'b000, 16'h8001, 16'h0004, 0, 0, 0, 0, 16'h0018, 0,0,0,0, 5,  1);
        issue(3'b010, 16'h0001, 16'h0001, 0, 0, 0, 0, 16'h8000, 0,0,0,1, 2,  1);
        issue(3'b001, 16'h1234, 16'h0000, 0, 0, 0, 0, 16'h1234, 0,0,0,0, 1,  1);
        issue(3'b100, 16'h7FFF, 16'h0001, 0, 0, 0, 1, 16'h8000, 1,0,0,1, 1,  1);
        issue(3'b100, 16'h7FFF, 16'h0001, 0, 0, 0, 0, 16'h8000, 0,0,0,1, 1,  1);
        issue(3'b100, 16'hFFFF, 16'h0000, 1, 0, 0, 0, 16'h0000, 1,1,1,0, 1,  1);
        issue(3'b001, 16'h0001, 16'hFFF0, 0, 0, 1, 0, 16'h8000, 0,0,0,1, 16, 1);
        issue(3'b011, 16'h8000, 16'h0003, 0, 0, 0, 0, 16'h1000, 0,0,0,0, 4,  1);
        issue(3'b101, 16'hF0F0, 16'hFF00, 1, 0, 0, 1, 16'hF000, 0,0,0,1, 1,  1);
        issue(3'b110, 16'h0F00, 16'h00F0, 1, 0, 0, 0, 16'h0FF0, 0,0,0,0, 1,  1);
        issue(3'b111, 16'hAAAA, 16'h5555, 0, 1, 1, 0, 16'hFFFF, 0,0,0,1, 1,  1);

        // Backpressure: response must hold while extra requests are refused.
        wait_idle();
        resp_ready = 1'b0;
        issue(3'b111, 16'h00FF, 16'h0F0F, 0, 1, 0, 0, 16'hF00F, 0,0,0,1, 1,  1);
        for (int i = 0; i < 20 && !resp_valid; i++) begin
            @(posedge clk); #1;
        end
        chk("hold_resp_valid_rise", {31'b0, resp_valid}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
            req_valid = 1'b1; Oper = 3'b100; InA = 16'h1111 * (i + 1); InB = 16'h0001;
            @(posedge clk); #1;
            chk("hold_resp_valid", {31'b0, resp_valid}, 32'd1);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        wait_idle();

        // Asynchronous reset in the middle of a long shift.
        issue(3'b011, 16'hFFFF, 16'h000F, 0, 0, 0, 0, 16'h0001, 0,0,0,0, 16, 0);
        repeat (6) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_outputs", {10'b0, resp_valid, Out, Ofl, Zero, Cout, Neg}, 32'd0);
        chk("async_rst_req_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        chk("post_rst_no_resp", {31'b0, resp_valid}, 32'd0);

        issue(3'b000, 16'h8001, 16'h0001, 0, 0, 0, 0, 16'h0003, 0,0,0,0, 2,  1);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
